// File: rtl/toggle_arb_pkg.sv
// Shared constants and FSM state type for the toggle event arbiter.
package toggle_arb_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int CNT_W_DEF = 4;
  localparam int TS_W      = 16;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping modulo N_CH.
module rr_pick #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic            gnt_valid,
  output logic [CH_W-1:0] gnt_idx
);

  logic [CH_W-1:0] idx;

  // NOTE: every output gets a default before the loop, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    // Walk from the farthest candidate back to ptr so the nearest one wins.
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = CH_W'((int'(ptr) + k) % N_CH);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/toggle_event_arbiter.sv
// Per-channel toggle detection, saturating event counters and round-robin
// serialisation onto one valid/ready port. Optional: EVT_TIMESTAMP_EN adds evt_ts.
module toggle_event_arbiter
  import toggle_arb_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int CH_W  = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] trigger,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_level,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] overflow
`ifdef EVT_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0] evt_ts
`endif
);

  logic [N_CH-1:0]  trig_q;
  logic [N_CH-1:0]  tog;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [CH_W-1:0]  rr_ptr;
  state_t           state_q, state_d;
  logic             gnt_valid;
  logic [CH_W-1:0]  gnt_idx;
  logic             grant;
  logic [N_CH-1:0]  gnt_vec;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  // trig_q tracks trigger even in reset, so levels held at release are silent.
  always_ff @(posedge clk) trig_q <= trigger;

  assign tog = trigger ^ trig_q;

  always_comb begin
    pending = '0;
    for (int i = 0; i < N_CH; i++) pending[i] = (cnt[i] != '0);
  end

  rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_pick (
    .req       (pending),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          grant   = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (evt_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_vec = '0;
    for (int i = 0; i < N_CH; i++) gnt_vec[i] = grant && (gnt_idx == CH_W'(i));
  end

  // NOTE: the counter array is cleared element by element in reset; it is
  // control state, not a storage RAM, so it must come up known.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
      overflow <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (tog[i] && !gnt_vec[i]) begin
          if (cnt[i] == '1) overflow[i] <= 1'b1;
          else              cnt[i]      <= cnt[i] + 1'b1;
        end else if (gnt_vec[i] && !tog[i]) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr    <= '0;
      evt_ch    <= '0;
      evt_level <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        evt_ch    <= gnt_idx;
        evt_level <= trigger[gnt_idx];
        rr_ptr    <= (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  assign evt_valid = (state_q == ST_PRESENT);

`ifdef EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // evt_ts is the count reached on the grant edge: N edges after reset reads N.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q   <= '0;
      evt_ts <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (grant) evt_ts <= ts_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_toggle_event_arbiter.sv
// Self-checking bench: event-count model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_toggle_event_arbiter;

  localparam int N    = 4;
  localparam int CMAX = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] trigger;
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_ch;
  logic         evt_level;
  logic [N-1:0] pending;
  logic [N-1:0] overflow;
`ifdef EVT_TIMESTAMP_EN
  logic [15:0]  evt_ts;
`endif

  toggle_event_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trigger),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_level (evt_level),
    .pending   (pending),
    .overflow  (overflow)
`ifdef EVT_TIMESTAMP_EN
    ,
    .evt_ts    (evt_ts)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-channel event counts, one presented event at a time.
  int           m_cnt [N];
  logic [N-1:0] m_ovf;
  logic [N-1:0] m_prev;
  bit           m_valid;
  int           m_ch;
  logic         m_lvl;
  int           m_ptr;
  int           m_ts_cnt;
  int           m_ts;

  always @(posedge clk) begin
    int g, c, d;
    if (rst) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_ovf = '0; m_valid = 0; m_ch = 0; m_lvl = 0; m_ptr = 0;
      m_ts_cnt = 0; m_ts = 0;
    end else begin
      g = -1;
      if (!m_valid) begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (g < 0 && m_cnt[c] > 0) g = c;
        end
      end else if (evt_ready) begin
        m_valid = 0;
      end
      for (int i = 0; i < N; i++) begin
        d = ((trigger[i] != m_prev[i]) ? 1 : 0) - ((i == g) ? 1 : 0);
        if (d > 0) begin
          if (m_cnt[i] == CMAX) m_ovf[i] = 1'b1;
          else m_cnt[i]++;
        end else if (d < 0) begin
          m_cnt[i]--;
        end
      end
      m_ts_cnt = (m_ts_cnt + 1) % 65536;
      if (g >= 0) begin
        m_valid = 1; m_ch = g; m_lvl = trigger[g]; m_ptr = (g + 1) % N; m_ts = m_ts_cnt;
      end
    end
    m_prev = trigger;
  end

  always @(negedge clk) begin
    logic [N-1:0] mp;
    if (chk_en) begin
      for (int i = 0; i < N; i++) mp[i] = (m_cnt[i] != 0);
      check("evt_valid", 32'(evt_valid), 32'(m_valid));
      check("pending", 32'(pending), 32'(mp));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (m_valid) begin
        check("evt_ch", 32'(evt_ch), 32'(m_ch));
        check("evt_level", 32'(evt_level), 32'(m_lvl));
`ifdef EVT_TIMESTAMP_EN
        check("evt_ts", 32'(evt_ts), 32'(m_ts));
`endif
      end
    end
  end

  task automatic reset_pulse();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int ch1_seen;
    int exp_v [7];
    int exp_c [7];
    int j;

    // 1: levels already high through reset raise nothing.
    rst = 1'b1; trigger = 4'b0101; evt_ready = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t1_valid", 32'(evt_valid), 32'd0);
    check("t1_pending", 32'(pending), 32'd0);

    // 2: single rising edge on ch2, uncontended latency.
    trigger = 4'b0000;
    reset_pulse();
    trigger = 4'b0100; evt_ready = 1'b1;
    @(negedge clk);
    check("t2_pend_t", 32'(pending), 32'b0100);
    check("t2_valid_t", 32'(evt_valid), 32'd0);
    @(negedge clk);
    check("t2_valid_t1", 32'(evt_valid), 32'd1);
    check("t2_ch", 32'(evt_ch), 32'd2);
    check("t2_level", 32'(evt_level), 32'd1);
    @(negedge clk);
    check("t2_valid_acc", 32'(evt_valid), 32'd0);
    check("t2_pend_acc", 32'(pending), 32'd0);

    // 3: simultaneous toggles on ch0, ch1, ch3 from rr_ptr=0.
    reset_pulse();
    trigger = trigger ^ 4'b1011;
    exp_v = '{0, 1, 0, 1, 0, 1, 0};
    exp_c = '{0, 0, 0, 1, 0, 3, 0};
    for (j = 0; j < 7; j++) begin
      @(negedge clk);
      check("t3_valid", 32'(evt_valid), 32'(exp_v[j]));
      if (exp_v[j] != 0) check("t3_ch", 32'(evt_ch), 32'(exp_c[j]));
    end

    // 4: saturate ch1 while a ch0 event is held unaccepted.
    evt_ready = 1'b0;
    trigger = trigger ^ 4'b0001;
    repeat (2) @(negedge clk);
    check("t4_hold_ch0", 32'(evt_ch), 32'd0);
    for (int k = 0; k < 17; k++) begin
      trigger = trigger ^ 4'b0010;
      @(negedge clk);
    end
    check("t4_ovf", 32'(overflow), 32'b0010);
    check("t4_model_ovf", 32'(m_ovf), 32'b0010);
    check("t4_pend", 32'(pending), 32'b0010);
    check("t4_still_ch0", 32'(evt_ch), 32'd0);
    evt_ready = 1'b1;
    ch1_seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (evt_valid && evt_ch == 2'd1) ch1_seen++;
    end
    check("t4_ch1_count", 32'(ch1_seen), 32'd15);
    check("t4_ovf_sticky", 32'(overflow), 32'b0010);
    check("t4_drained", 32'(pending), 32'd0);

    // 5: toggle on the grant edge keeps the count at 1.
    reset_pulse();
    check("t5_ovf_clr", 32'(overflow), 32'd0);
    trigger = trigger ^ 4'b0001;
    @(negedge clk);
    check("t5_pend_t", 32'(pending), 32'b0001);
    trigger = trigger ^ 4'b0001;
    @(negedge clk);
    check("t5_valid1", 32'(evt_valid), 32'd1);
    check("t5_pend_gnt", 32'(pending), 32'b0001);
    @(negedge clk);
    check("t5_acc", 32'(evt_valid), 32'd0);
    @(negedge clk);
    check("t5_valid2", 32'(evt_valid), 32'd1);
    check("t5_ch2nd", 32'(evt_ch), 32'd0);
    check("t5_pend_end", 32'(pending), 32'd0);
    @(negedge clk);

    // 6: reset while presenting drops everything.
    evt_ready = 1'b0;
    trigger = trigger ^ 4'b1000;
    repeat (2) @(negedge clk);
    check("t6_present", 32'(evt_valid), 32'd1);
    trigger = trigger ^ 4'b0100;
    @(negedge clk);
    check("t6_pend_pre", 32'(pending), 32'b0100);
    reset_pulse();
    check("t6_valid", 32'(evt_valid), 32'd0);
    check("t6_pend", 32'(pending), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
`ifdef EVT_TIMESTAMP_EN
    repeat (3) @(negedge clk);
    trigger = trigger ^ 4'b0010;
    repeat (2) @(negedge clk);
    check("t6_ts", 32'(evt_ts), 32'd5);
`endif

    // Randomized traffic with bursts of back-pressure and rare resets.
    for (int seg = 0; seg < 6; seg++) begin
      int ready_pct;
      ready_pct = (seg % 2 == 0) ? 80 : 15;
      for (int k = 0; k < 500; k++) begin
        if ($urandom_range(0, 3) == 0) trigger = trigger ^ 4'($urandom);
        evt_ready = ($urandom_range(0, 99) < ready_pct);
        rst = ($urandom_range(0, 399) == 0);
        @(negedge clk);
      end
    end
    rst = 1'b0;
    evt_ready = 1'b1;
    repeat (40) @(negedge clk);
    check("final_drained", 32'(pending), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/toggle_event_arbiter.md
Name: toggle_event_arbiter

Overview:
- Watches N_CH synchronous trigger inputs, each with a per-channel toggle detector.
- Queues toggle events per channel in saturating counters.
- Round-robin arbitration serialises the events onto one valid/ready event port.
- Feeds a single downstream consumer (logger/UART formatter) that services one toggle event at a time.

Parameters:
N_CH, 4, number of trigger channels (2..16)
CNT_W, 4, width of each channel's pending-event counter
CH_W, $clog2(N_CH), channel index width (derived; do not override)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
trigger  input  N_CH  level inputs, already synchronous to clk
evt_valid  output  1  event presented on evt_* outputs
evt_ready  input  1  consumer accepts event when high with evt_valid
evt_ch  output  CH_W  channel index of presented event
evt_level  output  1  trigger level of evt_ch at grant time
pending  output  N_CH  bit i high when cnt[i] != 0
overflow  output  N_CH  sticky: bit i set when channel i lost an event

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - evt_valid=0, evt_ch=0, evt_level=0.
  - All cnt=0, pending=0, overflow=0.
  - rr_ptr=0, state=IDLE.
  - trig_q <= trigger during reset, so a level already high at reset release raises no event.
- Toggle detection: tog[i] = trigger[i] ^ trig_q[i]; trig_q updates every edge.
- Counter update per channel, per edge:
  - +1 if tog[i].
  - -1 if channel i is granted this edge.
  - Both on the same edge: net unchanged.
  - Increment at cnt = 2^CNT_W-1 with no decrement: cnt holds and overflow[i] sets.
  - overflow clears only on rst.
- FSM, two states:
  - IDLE: if any cnt != 0, grant the first nonzero channel searching from rr_ptr upward, wrapping modulo N_CH.
    - Register evt_ch = granted index and evt_level = trigger[granted] at that edge.
    - Set evt_valid=1, set rr_ptr = granted+1 (wrap), go to PRESENT.
    - Counters are tested before this edge's increments, so an event that is still incrementing is not yet visible to the grant.
  - PRESENT: evt_* held stable while evt_valid && !evt_ready.
    - On evt_valid && evt_ready: evt_valid=0, return to IDLE.
    - No back-to-back grant on the accepting edge.
- Throughput: at most one event per 2 cycles.
- Latency, idle and uncontended: trigger change sampled at edge t gives cnt=1 at t, evt_valid=1 after edge t+1.
- Fairness: a channel with pending events waits at most N_CH-1 grants.
- pending is combinational from the counters.
- rst mid-PRESENT: event dropped, all state returns to reset values on that edge.
- evt_ready ignored in IDLE.

Optional Feature:
- Macro: EVT_TIMESTAMP_EN.
- Defined:
  - Adds output evt_ts [15:0].
  - A free-running 16-bit counter resets to 0, increments every cycle and wraps 0xFFFF->0.
  - evt_ts captures the counter value on the grant edge and is held with evt_*.
- Undefined: no port and no counter; all other behaviour is identical.

Decomposition:
- Package toggle_arb_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_PRESENT=1'b1.
  - default widths (N_CH_DEF=4, CNT_W_DEF=4, TS_W=16).
- One sub-module: rr_pick, combinational.
  - Inputs: req[N_CH], ptr[CH_W].
  - Outputs: gnt_valid and gnt_idx.
- Toggle detection and counters stay inline in the top.

Test Plan:
1. Reset with trigger=4'b0101 held, release rst, hold trigger -> evt_valid stays 0 for 20 cycles and pending=0.
2. Ch2 0->1 at edge t, evt_ready=1 -> evt_valid=1 after t+1 with evt_ch=2, evt_level=1; accepted next edge; pending[2]=0.
3. Ch0, ch1, ch3 toggle on the same edge, rr_ptr=0, evt_ready=1 -> grants in order ch0, ch1, ch3, one every 2 cycles; then evt_valid=0.
4. evt_ready=0; ch1 toggles 17 times (CNT_W=4) -> cnt[1]=15 and overflow[1]=1. Then evt_ready=1 -> exactly 15 ch1 events delivered. overflow[1] stays 1 until rst.
5. Ch0 toggles on the same edge it is granted, with cnt[0]=1 -> cnt[0] stays 1 and a second ch0 event follows.
6. rst pulsed for 1 cycle while in PRESENT with evt_ready=0 -> next cycle evt_valid=0 and all cnt=0. With EVT_TIMESTAMP_EN, first grant 5 cycles after release reads evt_ts=5.
